// File: rtl/spi_mem_ctrl.sv
// SPI master (mode 0, SCK = clk/2) for single 16-bit word reads/writes to a serial RAM.
// One 48-bit frame per request: command, 24-bit address, 16 data bits, MSB first.
module spi_mem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [23:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        spi_select,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [5:0] LAST_BIT  = 6'd47;
  localparam logic [5:0] DATA_BIT0 = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [47:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rdata_q, rdata_d;
  logic        write_q, write_d;
  logic        sel_q, sel_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [47:0] frame;

  assign frame = {(write ? CMD_WRITE : CMD_READ), addr, (write ? wdata : 16'h0000)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      phase_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      sel_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    write_d = write_q;
    sel_d   = sel_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      // DONE also accepts start so a back-to-back request sees select low for one cycle only.
      IDLE, DONE: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d = SHIFT;
          write_d = write;
          tx_d    = frame;
          bit_d   = '0;
          phase_d = 1'b0;
          sel_d   = 1'b1;
          busy_d  = 1'b1;
          mosi_d  = frame[47];
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          sck_d   = 1'b1;
          phase_d = 1'b1;
          if (!write_q && (bit_q >= DATA_BIT0)) rx_d = {rx_q[14:0], spi_miso};
        end else if (bit_q == LAST_BIT) begin
          state_d = DONE;
          sel_d   = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!write_q) rdata_d = rx_q;
        end else begin
          bit_d   = bit_q + 6'd1;
          phase_d = 1'b0;
          sck_d   = 1'b0;
          tx_d    = {tx_q[46:0], 1'b0};
          mosi_d  = tx_q[46];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_select = sel_q;
  assign spi_clk    = sck_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural mode-0 SPI RAM and a pin-level protocol monitor.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        busy, done, spi_select, spi_clk, spi_mosi, spi_miso;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .spi_select(spi_select), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // SPI RAM model: samples MOSI on SCK rise, presents the next MISO bit while SCK is low.
  logic [7:0]  mem [0:255];
  logic [47:0] rx_frame = '0;
  logic [47:0] last_frame = '0;
  logic [23:0] cap_addr = '0;
  logic [15:0] rd_sh = '0;
  logic [5:0]  bcnt = '0;
  logic        is_read = 1'b0;
  logic [7:0]  wa;

  always @(posedge spi_select) begin
    bcnt = '0;
    is_read = 1'b0;
  end

  always @(posedge spi_clk) begin
    if (spi_select) begin
      rx_frame = {rx_frame[46:0], spi_mosi};
      if (bcnt >= 6'd32) rd_sh = {rd_sh[14:0], 1'b0};
      bcnt = bcnt + 6'd1;
      if (bcnt == 6'd8) is_read = (rx_frame[7:0] == 8'h03);
      if (bcnt == 6'd32) begin
        cap_addr = rx_frame[23:0];
        wa = rx_frame[7:0];
        rd_sh = {mem[wa], mem[wa + 8'd1]};
      end
      if (bcnt == 6'd48) begin
        last_frame = rx_frame;
        if (rx_frame[47:40] == 8'h02) begin
          wa = rx_frame[23:16];
          mem[wa] = rx_frame[15:8];
          mem[wa + 8'd1] = rx_frame[7:0];
        end
      end
    end
  end

  assign spi_miso = (spi_select && is_read && (bcnt >= 6'd32) && (bcnt < 6'd48)) ? rd_sh[15] : 1'b0;

  // Pin monitor, sampled mid-cycle.
  int sel_len = 0, last_len = 0, pulses = 0, last_pulses = 0;
  int gap = 1000, last_gap = 0, viol = 0, done_cnt = 0, frame_cnt = 0;
  logic p_sel = 1'b0, p_sck = 1'b0, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (spi_select && !p_sel) begin
      sel_len = 0;
      pulses = 0;
      last_gap = gap;
      frame_cnt++;
      if (spi_clk) viol++;
    end
    if (spi_select) begin
      sel_len++;
      gap = 0;
    end else begin
      gap++;
      if (spi_clk) viol++;
    end
    if (spi_clk && !p_sck) pulses++;
    if ((spi_mosi != p_mosi) && spi_clk) viol++;
    if (!spi_select && p_sel) begin
      last_len = sel_len;
      last_pulses = pulses;
    end
    if (done) done_cnt++;
    p_sel = spi_select;
    p_sck = spi_clk;
    p_mosi = spi_mosi;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns in the done cycle; lat counts cycles from start to done.
  task automatic do_txn(input logic w, input logic [23:0] a, input logic [15:0] d, output int lat);
    write = w;
    addr = a;
    wdata = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_next_cycle", {63'd0, busy}, 64'd1);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    if (lat >= 200) chk("done_timeout", 64'd0, 64'd1);
  endtask

  int lat, d0, f0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h12;
    mem[8'h11] = 8'h34;
    mem[8'h40] = 8'h99;
    mem[8'h41] = 8'h77;

    tick();
    tick();
    chk("rst_rdata", {48'd0, rdata}, 64'h0);
    chk("rst_outs", {58'd0, busy, done, spi_select, spi_clk, spi_mosi}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Read 0x000010
    do_txn(1'b0, 24'h000010, 16'h0000, lat);
    chk("read_latency", 64'(lat), 64'd97);
    chk("read_rdata", {48'd0, rdata}, 64'h1234);
    chk("read_busy_in_done", {63'd0, busy}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    tick();
    tick();
    chk("read_rdata_hold", {48'd0, rdata}, 64'h1234);
    chk("read_sel_len", 64'(last_len), 64'd96);

    // Write 0xBEEF to 0x000020
    do_txn(1'b1, 24'h000020, 16'hBEEF, lat);
    chk("write_latency", 64'(lat), 64'd97);
    chk("write_frame", {16'd0, last_frame}, 64'h0200_0020_BEEF);
    tick();
    chk("write_sck_pulses", 64'(last_pulses), 64'd48);
    chk("write_sel_len", 64'(last_len), 64'd96);
    chk("write_mem_hi", {56'd0, mem[8'h20]}, 64'hBE);
    chk("write_mem_lo", {56'd0, mem[8'h21]}, 64'hEF);
    chk("write_keeps_rdata", {48'd0, rdata}, 64'h1234);
    tick();

    // Back-to-back: write then read issued in the done cycle
    do_txn(1'b1, 24'h0000FE, 16'hA55A, lat);
    do_txn(1'b0, 24'h0000FE, 16'h0000, lat);
    chk("b2b_gap", 64'(last_gap), 64'd1);
    chk("b2b_latency", 64'(lat), 64'd97);
    chk("b2b_rdata", {48'd0, rdata}, 64'hA55A);
    chk("b2b_addr", {40'd0, cap_addr}, 64'h0000FE);
    tick();

    // Start while busy is ignored
    d0 = done_cnt;
    f0 = frame_cnt;
    write = 1'b0;
    addr = 24'h000010;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 30) begin
      tick();
      lat++;
    end
    addr = 24'h000040;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    if (lat >= 200) chk("busy_done_timeout", 64'd0, 64'd1);
    chk("busy_latency", 64'(lat), 64'd97);
    chk("busy_rdata", {48'd0, rdata}, 64'h1234);
    for (int i = 0; i < 150; i++) tick();
    chk("busy_done_count", 64'(done_cnt - d0), 64'd1);
    chk("busy_frame_count", 64'(frame_cnt - f0), 64'd1);
    chk("busy_idle_after", {63'd0, busy}, 64'd0);

    // Reset in the middle of a read
    write = 1'b0;
    addr = 24'h000010;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 50) begin
      tick();
      lat++;
    end
    chk("pre_rst_sel_sck", {62'd0, spi_select, spi_clk}, 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {58'd0, busy, done, spi_select, spi_clk, spi_mosi}, 64'h0);
    chk("async_rst_rdata", {48'd0, rdata}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, 24'h000010, 16'h0000, lat);
    chk("post_rst_rdata", {48'd0, rdata}, 64'h1234);
    tick();
    tick();

    chk("sck_mosi_protocol", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
